lcd_scan_driver: RTL and testbench
==================================

Name: lcd_scan_driver

Overview:
- Parametrised successor to the alarm-clock LCD decoder.
- Selects one of three multi-digit BCD time sources and snapshots it once per frame.
- Streams each digit as an ASCII character to the LCD controller over a valid/ready handshake, blinking the display while a new time is being keyed.
- Generates a latched, timed sound_alarm when current time reaches alarm time.

Parameters:
DIGITS, 4, number of BCD digits per time value (1..8)
IDX_W, 2, width of lcd_digit_idx; must satisfy 2**IDX_W >= DIGITS
BLINK_DIV, 256, clock cycles per blink half-period (>=2)
ALARM_CYCLES, 1000, sound_alarm duration in cycles; 0 = sound until stopped
CNT_W, 16, width of alarm and blink counters; must hold ALARM_CYCLES and BLINK_DIV-1

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
alarm_time  in  4*DIGITS  alarm setting, digit 0 in bits [3:0]
key  in  4*DIGITS  keypad-entered new time
current_time  in  4*DIGITS  running time
show_alarm  in  1  display alarm_time
show_new_time  in  1  display key (blinking)
alarm_enable  in  1  arms alarm; low clears sound_alarm
stop_alarm  in  1  clears sound_alarm
lcd_ready  in  1  LCD controller accepts character
lcd_valid  out  1  lcd_data/lcd_digit_idx valid
lcd_data  out  8  ASCII character
lcd_digit_idx  out  IDX_W  digit position of lcd_data
lcd_sof  out  1  high with the first (most significant) character of a frame
sound_alarm  out  1  alarm sounding

Behaviour:
- Reset (sync, active-high): state=SNAP; lcd_valid=0, lcd_data=8'h00, lcd_digit_idx=0, lcd_sof=0, sound_alarm=0; blink counter=0, blink_phase=0; alarm counter=0, match_d=0. Reset mid-frame abandons the frame; no partial resume.
- Source priority: show_new_time > show_alarm > current_time.
- FSM SNAP: one cycle with lcd_valid=0. Captures the selected source into a frame buffer, plus blank = show_new_time & blink_phase. Sets idx=DIGITS-1. Next state SEND.
- FSM SEND: lcd_valid=1; lcd_data = char(frame_buf[idx]), or 8'h20 if blank; lcd_sof=1 only when idx=DIGITS-1.
  - Outputs are held stable while lcd_ready=0.
  - On lcd_ready=1: if idx=0, go to SNAP (lcd_valid=0 next cycle); else idx-1 next cycle.
- Frame length = DIGITS accepted transfers + 1 SNAP cycle. Minimum with ready tied high: DIGITS+1 cycles.
- Input changes mid-frame do not affect the current frame.
- Decode: BCD 0..9 -> 8'h30..8'h39; 10..15 -> 8'h3A (ERROR).
- Blink: counter runs 0..BLINK_DIV-1 continuously; at wrap, toggles blink_phase. blink_phase is sampled only in SNAP.
- Alarm match: match = (current_time == alarm_time) over the full width; match_d = match registered.
- Alarm set: when match & ~match_d & alarm_enable, sound_alarm=1 next cycle and the counter loads ALARM_CYCLES.
- Alarm count: while sounding with ALARM_CYCLES>0, the counter decrements each cycle; the cycle it reaches 1, sound_alarm clears next edge. Duration is exactly ALARM_CYCLES cycles.
- Alarm clear: stop_alarm=1 or alarm_enable=0 clears sound_alarm next cycle. Clear wins over a simultaneous new match edge.
- A match held high does not retrigger. A new rising edge while already sounding reloads the counter.
- Alarm logic is independent of show_* and the LCD handshake.

Test Plan:
- DIGITS=4, current_time=16'h1234, show_* low, lcd_ready=1 -> stream 0x31,0x32,0x33,0x34 with idx 3,2,1,0; lcd_sof on first; lcd_valid low 1 cycle; frame repeats every 5 cycles.
- show_alarm=1 and show_new_time=1, key=16'h0959, alarm_time=16'h0700 -> key shown (0x30,0x39,0x35,0x39). Blanked frames (all 0x20) alternate with shown frames per BLINK_DIV phase. Drop show_new_time -> 0x30,0x37,0x30,0x30.
- lcd_ready low 7 cycles on second character -> lcd_data=0x32, idx=2 held stable all 7 cycles. current_time changes to 16'h9999 mid-frame -> remaining chars still 0x33,0x34.
- current_time digit 1 = 4'hC -> that character is 0x3A, others decoded normally.
- ALARM_CYCLES=10, alarm_enable=1, current_time steps 16'h0659->16'h0700=alarm_time -> sound_alarm rises next cycle and stays high exactly 10 cycles; the held match does not retrigger.
- stop_alarm asserted the same cycle as a match rising edge -> sound_alarm stays 0. Reset asserted mid-SEND -> next cycle lcd_valid=0, sound_alarm=0, then a fresh SNAP and lcd_sof on idx 3.

Source files
------------

// File: rtl/lcd_scan_driver.sv
// Multi-digit BCD time to ASCII LCD streamer with frame snapshot, blink and timed alarm.
// Each frame latches one time source, then sends its digits most-significant first over valid/ready.
module lcd_scan_driver #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned IDX_W        = 2,
    parameter int unsigned BLINK_DIV    = 256,
    parameter int unsigned ALARM_CYCLES = 1000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   alarm_time,
    input  logic [4*DIGITS-1:0]   key,
    input  logic [4*DIGITS-1:0]   current_time,
    input  logic                  show_alarm,
    input  logic                  show_new_time,
    input  logic                  alarm_enable,
    input  logic                  stop_alarm,
    input  logic                  lcd_ready,
    output logic                  lcd_valid,
    output logic [7:0]            lcd_data,
    output logic [IDX_W-1:0]      lcd_digit_idx,
    output logic                  lcd_sof,
    output logic                  sound_alarm
);

    typedef enum logic {SNAP, SEND} state_t;

    state_t               state, state_next;
    logic [4*DIGITS-1:0]  src, frame_buf;
    logic [IDX_W-1:0]     idx;
    logic                 blank;
    logic                 blink_phase;
    logic [CNT_W-1:0]     blink_cnt;
    logic [CNT_W-1:0]     alarm_cnt;
    logic                 match, match_d, match_rise, alarm_clear;
    logic [3:0]           digit;

    function automatic logic [7:0] bcd_char(input logic [3:0] d);
        return (d <= 4'd9) ? {4'h3, d} : 8'h3A;
    endfunction

    always_comb begin
        if (show_new_time)   src = key;
        else if (show_alarm) src = alarm_time;
        else                 src = current_time;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= SNAP;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_buf <= '0;
            idx       <= '0;
            blank     <= 1'b0;
        end else if (state == SNAP) begin
            frame_buf <= src;
            blank     <= show_new_time & blink_phase;
            idx       <= IDX_W'(DIGITS - 1);
        end else if (lcd_ready && idx != '0) begin
            idx <= idx - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        digit = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) digit = frame_buf[i*4 +: 4];
        end
    end

    always_comb begin
        state_next    = state;
        lcd_valid     = 1'b0;
        lcd_data      = 8'h00;
        lcd_digit_idx = '0;
        lcd_sof       = 1'b0;
        case (state)
            SNAP: state_next = SEND;
            SEND: begin
                lcd_valid     = 1'b1;
                lcd_data      = blank ? 8'h20 : bcd_char(digit);
                lcd_digit_idx = idx;
                lcd_sof       = (idx == IDX_W'(DIGITS - 1));
                if (lcd_ready && idx == '0) state_next = SNAP;
            end
            default: state_next = SNAP;
        endcase
    end

    assign match       = (current_time == alarm_time);
    assign match_rise  = match & ~match_d & alarm_enable;
    assign alarm_clear = stop_alarm | ~alarm_enable;

    // Clear has priority over a new edge; a zero duration parameter means sound until cleared.
    always_ff @(posedge clock) begin
        if (reset) begin
            match_d     <= 1'b0;
            sound_alarm <= 1'b0;
            alarm_cnt   <= '0;
        end else begin
            match_d <= match;
            if (alarm_clear) begin
                sound_alarm <= 1'b0;
                alarm_cnt   <= '0;
            end else if (match_rise) begin
                sound_alarm <= 1'b1;
                alarm_cnt   <= CNT_W'(ALARM_CYCLES);
            end else if (sound_alarm && ALARM_CYCLES != 0) begin
                if (alarm_cnt == CNT_W'(1)) begin
                    sound_alarm <= 1'b0;
                    alarm_cnt   <= '0;
                end else begin
                    alarm_cnt <= alarm_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_scan_driver.sv
// Directed bench for lcd_scan_driver: frame streaming table, stall, blink, alarm and reset sequences.
module tb_lcd_scan_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] alarm_time, key, current_time;
    logic        show_alarm, show_new_time, alarm_enable, stop_alarm, lcd_ready;
    logic        lcd_valid;
    logic [7:0]  lcd_data;
    logic [1:0]  lcd_digit_idx;
    logic        lcd_sof;
    logic        sound_alarm;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lcd_scan_driver #(
        .DIGITS(4), .IDX_W(2), .BLINK_DIV(16), .ALARM_CYCLES(10), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset),
        .alarm_time(alarm_time), .key(key), .current_time(current_time),
        .show_alarm(show_alarm), .show_new_time(show_new_time),
        .alarm_enable(alarm_enable), .stop_alarm(stop_alarm), .lcd_ready(lcd_ready),
        .lcd_valid(lcd_valid), .lcd_data(lcd_data), .lcd_digit_idx(lcd_digit_idx),
        .lcd_sof(lcd_sof), .sound_alarm(sound_alarm)
    );

    typedef struct {
        logic [15:0] cur;
        logic [15:0] alm;
        logic        sa;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_sof(input string name);
        int n = 0;
        while (!(lcd_valid === 1'b1 && lcd_sof === 1'b1) && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_sof_timeout"}, 32'(n < 100), 32'd1);
    endtask

    task automatic read_frame(output logic [31:0] chars, output logic [7:0] idxs,
                              output logic [3:0] sofs, output logic valids);
        chars  = '0;
        idxs   = '0;
        sofs   = '0;
        valids = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chars  = {chars[23:0], lcd_data};
            idxs   = {idxs[5:0], lcd_digit_idx};
            sofs   = {sofs[2:0], lcd_sof};
            valids = valids & lcd_valid;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] chars;
        logic [7:0]  idxs;
        logic [3:0]  sofs;
        logic        valids;
        int          shown, blanked, hi;

        vecs[0] = '{16'h1234, 16'h0000, 1'b0, 32'h31323334};
        vecs[1] = '{16'h12C4, 16'h0000, 1'b0, 32'h31323A34};
        vecs[2] = '{16'h1234, 16'h0700, 1'b1, 32'h30373030};
        vecs[3] = '{16'h0000, 16'h0700, 1'b0, 32'h30303030};
        vecs[4] = '{16'hFA98, 16'h0700, 1'b0, 32'h3A3A3938};

        reset = 1'b1; alarm_time = '0; key = '0; current_time = '0;
        show_alarm = 1'b0; show_new_time = 1'b0; alarm_enable = 1'b0;
        stop_alarm = 1'b0; lcd_ready = 1'b1;
        tick(); tick();
        chk("reset_outputs", {19'd0, lcd_valid, lcd_data, lcd_digit_idx, lcd_sof, sound_alarm}, 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            current_time = vecs[v].cur;
            alarm_time   = vecs[v].alm;
            show_alarm   = vecs[v].sa;
            tick();
            wait_sof("table");
            read_frame(chars, idxs, sofs, valids);
            chk("table_chars", chars, vecs[v].exp);
            chk("table_idx", {24'd0, idxs}, 32'h000000E4);
            chk("table_sof", {28'd0, sofs}, 32'h8);
            chk("table_valid", {31'd0, valids}, 32'd1);
            chk("table_snap_gap", {31'd0, lcd_valid}, 32'd0);
        end

        tick();
        chk("sof_after_gap", {30'd0, lcd_valid, lcd_sof}, 32'd3);
        repeat (5) tick();
        chk("frame_period", {30'd0, lcd_valid, lcd_sof}, 32'd3);

        // Stall on the second character, and change the source mid-frame.
        show_alarm = 1'b0; current_time = 16'h1234;
        tick();
        wait_sof("stall");
        tick();
        lcd_ready = 1'b0; current_time = 16'h9999;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("stall_hold", {21'd0, lcd_valid, lcd_digit_idx, lcd_data}, {21'd0, 1'b1, 2'd2, 8'h32});
        end
        lcd_ready = 1'b1;
        tick();
        chk("after_stall_c1", {21'd0, lcd_valid, lcd_digit_idx, lcd_data}, {21'd0, 1'b1, 2'd1, 8'h33});
        tick();
        chk("after_stall_c0", {21'd0, lcd_valid, lcd_digit_idx, lcd_data}, {21'd0, 1'b1, 2'd0, 8'h34});
        tick();
        chk("after_stall_snap", {31'd0, lcd_valid}, 32'd0);
        tick();
        chk("new_frame_9999", {23'd0, lcd_sof, lcd_data}, {23'd0, 1'b1, 8'h39});

        // Blinking key entry: every frame fully shown or fully blank, both seen.
        show_new_time = 1'b1; show_alarm = 1'b1; key = 16'h0959; alarm_time = 16'h0700;
        tick();
        shown = 0; blanked = 0;
        for (int f = 0; f < 12; f++) begin
            wait_sof("blink");
            read_frame(chars, idxs, sofs, valids);
            if (chars[31:24] == 8'h20) begin
                blanked++;
                chk("blink_blank_frame", chars, 32'h20202020);
            end else begin
                shown++;
                chk("blink_shown_frame", chars, 32'h30393539);
            end
        end
        chk("blink_both_phases", {30'd0, shown > 0, blanked > 0}, 32'd3);
        show_new_time = 1'b0;
        tick();
        wait_sof("alarm_view");
        read_frame(chars, idxs, sofs, valids);
        chk("alarm_view_chars", chars, 32'h30373030);

        // Timed alarm.
        show_alarm = 1'b0; alarm_time = 16'h0700; current_time = 16'h0659; alarm_enable = 1'b1;
        repeat (3) tick();
        chk("alarm_idle", {31'd0, sound_alarm}, 32'd0);
        current_time = 16'h0700;
        tick();
        chk("alarm_rise", {31'd0, sound_alarm}, 32'd1);
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            hi += int'(sound_alarm);
        end
        chk("alarm_duration", 32'(hi), 32'd10);

        current_time = 16'h0659;
        repeat (2) tick();
        current_time = 16'h0700; stop_alarm = 1'b1;
        tick();
        chk("stop_beats_edge", {31'd0, sound_alarm}, 32'd0);
        stop_alarm = 1'b0;
        repeat (3) tick();
        chk("held_match_no_retrigger", {31'd0, sound_alarm}, 32'd0);

        current_time = 16'h0659;
        repeat (2) tick();
        current_time = 16'h0700;
        tick();
        chk("alarm_rise2", {31'd0, sound_alarm}, 32'd1);
        alarm_enable = 1'b0;
        tick();
        chk("enable_low_clears", {31'd0, sound_alarm}, 32'd0);

        // Reset in the middle of a frame while the alarm sounds.
        alarm_enable = 1'b1; current_time = 16'h0659;
        repeat (2) tick();
        current_time = 16'h0700;
        tick();
        wait_sof("reset_mid");
        tick();
        chk("pre_reset_state", {30'd0, lcd_valid, sound_alarm}, 32'd3);
        reset = 1'b1; alarm_enable = 1'b0;
        tick();
        chk("reset_mid_send", {30'd0, lcd_valid, sound_alarm}, 32'd0);
        reset = 1'b0;
        tick();
        chk("fresh_frame", {20'd0, lcd_valid, lcd_sof, lcd_digit_idx, lcd_data},
            {20'd0, 1'b1, 1'b1, 2'd3, 8'h30});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
